// File: rtl/apple_spawner_if.sv
`default_nettype none
// ============================================================================
// Module   : apple_spawner_if
// Brief    : Occupancy query handshake between the apple spawner and the
//            snake body module.
// Revision : 1.0
// ============================================================================
interface apple_spawner_if #(
    parameter int X_W = 6,
    parameter int Y_W = 5
);
    logic           Occ_req;
    logic [X_W-1:0] Occ_x;
    logic [Y_W-1:0] Occ_y;
    logic           Occ_ack;
    logic           Occ_hit;

    modport master (
        output Occ_req, Occ_x, Occ_y,
        input  Occ_ack, Occ_hit
    );

    modport slave (
        input  Occ_req, Occ_x, Occ_y,
        output Occ_ack, Occ_hit
    );
endinterface
`default_nettype wire

// File: rtl/apple_spawner.sv
`default_nettype none
// ============================================================================
// Module   : apple_spawner
// Brief    : LFSR-driven apple placement with playfield/head/body rejection,
//            periodic bonus apples with a tick-based lifetime.
// Revision : 1.0
// ============================================================================
module apple_spawner #(
    parameter int          X_W         = 6,
    parameter int          Y_W         = 5,
    parameter int          X_MIN       = 1,
    parameter int          X_MAX       = 38,
    parameter int          Y_MIN       = 1,
    parameter int          Y_MAX       = 28,
    parameter int          INIT_X      = 28,
    parameter int          INIT_Y      = 13,
    parameter int          TICK_CYCLES = 250000,
    parameter int          BONUS_EVERY = 5,
    parameter int          BONUS_LIFE  = 20,
    parameter int          MAX_TRY     = 64,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  wire logic           Clk_50mhz,
    input  wire logic           Rst_n,
    input  wire logic [X_W-1:0] Head_x,
    input  wire logic [Y_W-1:0] Head_y,
    apple_spawner_if.master     occ,
    output logic [X_W-1:0]      Apple_x,
    output logic [Y_W-1:0]      Apple_y,
    output logic                Apple_type,
    output logic                Apple_valid,
    output logic                Body_add_sig,
    output logic                Bonus_sig,
    output logic                Spawn_fail
);

    localparam int c_TCW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int c_SCW = (BONUS_EVERY > 1) ? $clog2(BONUS_EVERY) : 1;
    localparam int c_LCW = (BONUS_LIFE > 1)  ? $clog2(BONUS_LIFE)  : 1;
    localparam int c_RTW = (MAX_TRY > 0)     ? $clog2(MAX_TRY + 1) : 1;

    localparam logic [c_TCW-1:0] c_TICK_LAST  = c_TCW'(TICK_CYCLES - 1);
    localparam logic [c_SCW-1:0] c_SPAWN_LAST = c_SCW'((BONUS_EVERY > 0) ? BONUS_EVERY - 1 : 0);
    localparam logic [c_LCW-1:0] c_LIFE_LAST  = c_LCW'((BONUS_LIFE > 0) ? BONUS_LIFE - 1 : 0);
    localparam logic [c_RTW-1:0] c_MAX_TRY    = c_RTW'(MAX_TRY);
    localparam logic             c_BONUS_EN   = (BONUS_EVERY != 0);
    localparam logic [15:0]      c_LFSR_MASK  = 16'hB400;

    localparam logic [X_W-1:0] c_X_MIN  = X_W'(X_MIN);
    localparam logic [X_W-1:0] c_X_MAX  = X_W'(X_MAX);
    localparam logic [Y_W-1:0] c_Y_MIN  = Y_W'(Y_MIN);
    localparam logic [Y_W-1:0] c_Y_MAX  = Y_W'(Y_MAX);
    localparam logic [X_W-1:0] c_INIT_X = X_W'(INIT_X);
    localparam logic [Y_W-1:0] c_INIT_Y = Y_W'(INIT_Y);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SAMPLE = 2'd1,
        S_CHECK  = 2'd2,
        S_PLACE  = 2'd3
    } state_t;

    state_t           r_state,      w_state_nxt;
    logic [15:0]      r_lfsr,       w_lfsr_nxt;
    logic [c_TCW-1:0] r_tick_cnt,   w_tick_cnt_nxt;
    logic [c_SCW-1:0] r_spawn_cnt,  w_spawn_cnt_nxt;
    logic [c_RTW-1:0] r_retry,      w_retry_nxt;
    logic [c_LCW-1:0] r_life,       w_life_nxt;
    logic             r_occ_req,    w_occ_req_nxt;
    logic [X_W-1:0]   r_occ_x,      w_occ_x_nxt;
    logic [Y_W-1:0]   r_occ_y,      w_occ_y_nxt;
    logic [X_W-1:0]   r_apple_x,    w_apple_x_nxt;
    logic [Y_W-1:0]   r_apple_y,    w_apple_y_nxt;
    logic             r_apple_type, w_apple_type_nxt;
    logic             r_apple_vld,  w_apple_vld_nxt;
    logic             r_body_add,   w_body_add_nxt;
    logic             r_bonus,      w_bonus_nxt;
    logic             r_fail,       w_fail_nxt;

    logic [X_W-1:0]   w_cx;
    logic [Y_W-1:0]   w_cy;
    logic             w_tick;
    logic             w_head_on_apple;
    logic             w_cand_ok;
    logic [c_RTW-1:0] w_retry_inc;
    logic             w_exhaust;
    logic [c_SCW-1:0] w_spawn_inc;

    assign w_cx            = r_lfsr[15 -: X_W];
    assign w_cy            = r_lfsr[Y_W-1:0];
    assign w_tick          = (r_tick_cnt == c_TICK_LAST);
    assign w_head_on_apple = (Head_x == r_apple_x) && (Head_y == r_apple_y);
    assign w_cand_ok       = (w_cx >= c_X_MIN) && (w_cx <= c_X_MAX) &&
                             (w_cy >= c_Y_MIN) && (w_cy <= c_Y_MAX) &&
                             !((w_cx == Head_x) && (w_cy == Head_y));
    // Fallback fires on the rejection that brings the count up to MAX_TRY.
    assign w_retry_inc     = r_retry + 1'b1;
    assign w_exhaust       = (w_retry_inc >= c_MAX_TRY);
    assign w_spawn_inc     = (r_spawn_cnt == c_SPAWN_LAST) ? '0 : r_spawn_cnt + 1'b1;

    always_comb begin
        w_state_nxt      = r_state;
        w_lfsr_nxt       = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_LFSR_MASK : 16'h0000);
        w_tick_cnt_nxt   = w_tick ? '0 : r_tick_cnt + 1'b1;
        w_spawn_cnt_nxt  = r_spawn_cnt;
        w_retry_nxt      = r_retry;
        w_life_nxt       = r_life;
        w_occ_req_nxt    = r_occ_req;
        w_occ_x_nxt      = r_occ_x;
        w_occ_y_nxt      = r_occ_y;
        w_apple_x_nxt    = r_apple_x;
        w_apple_y_nxt    = r_apple_y;
        w_apple_type_nxt = r_apple_type;
        w_apple_vld_nxt  = r_apple_vld;
        w_body_add_nxt   = 1'b0;
        w_bonus_nxt      = 1'b0;
        w_fail_nxt       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_tick && r_apple_vld && w_head_on_apple) begin
                    w_body_add_nxt  = 1'b1;
                    w_bonus_nxt     = r_apple_type;
                    w_apple_vld_nxt = 1'b0;
                    w_state_nxt     = S_SAMPLE;
                end else if (w_tick && r_apple_type && (r_life == c_LIFE_LAST)) begin
                    w_apple_vld_nxt = 1'b0;
                    w_state_nxt     = S_SAMPLE;
                end else if (w_tick && r_apple_type) begin
                    w_life_nxt = r_life + 1'b1;
                end
            end

            S_SAMPLE: begin
                w_occ_x_nxt = w_cx;
                w_occ_y_nxt = w_cy;
                if (w_cand_ok) begin
                    w_occ_req_nxt = 1'b1;
                    w_state_nxt   = S_CHECK;
                end else begin
                    w_retry_nxt = w_retry_inc;
                    if (w_exhaust) begin
                        w_occ_x_nxt = c_X_MIN;
                        w_occ_y_nxt = c_Y_MIN;
                        w_fail_nxt  = 1'b1;
                        w_state_nxt = S_PLACE;
                    end
                end
            end

            S_CHECK: begin
                if (r_occ_req && occ.Occ_ack) begin
                    w_occ_req_nxt = 1'b0;
                    if (occ.Occ_hit) begin
                        w_retry_nxt = w_retry_inc;
                        if (w_exhaust) begin
                            w_occ_x_nxt = c_X_MIN;
                            w_occ_y_nxt = c_Y_MIN;
                            w_fail_nxt  = 1'b1;
                            w_state_nxt = S_PLACE;
                        end else begin
                            w_state_nxt = S_SAMPLE;
                        end
                    end else begin
                        w_state_nxt = S_PLACE;
                    end
                end
            end

            S_PLACE: begin
                w_apple_x_nxt    = r_occ_x;
                w_apple_y_nxt    = r_occ_y;
                w_apple_vld_nxt  = 1'b1;
                w_spawn_cnt_nxt  = w_spawn_inc;
                w_apple_type_nxt = c_BONUS_EN && (w_spawn_inc == '0);
                w_life_nxt       = '0;
                w_retry_nxt      = '0;
                w_state_nxt      = S_IDLE;
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk_50mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state      <= S_IDLE;
            r_lfsr       <= LFSR_SEED;
            r_tick_cnt   <= '0;
            r_spawn_cnt  <= '0;
            r_retry      <= '0;
            r_life       <= '0;
            r_occ_req    <= 1'b0;
            r_occ_x      <= '0;
            r_occ_y      <= '0;
            r_apple_x    <= c_INIT_X;
            r_apple_y    <= c_INIT_Y;
            r_apple_type <= 1'b0;
            r_apple_vld  <= 1'b1;
            r_body_add   <= 1'b0;
            r_bonus      <= 1'b0;
            r_fail       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_lfsr       <= w_lfsr_nxt;
            r_tick_cnt   <= w_tick_cnt_nxt;
            r_spawn_cnt  <= w_spawn_cnt_nxt;
            r_retry      <= w_retry_nxt;
            r_life       <= w_life_nxt;
            r_occ_req    <= w_occ_req_nxt;
            r_occ_x      <= w_occ_x_nxt;
            r_occ_y      <= w_occ_y_nxt;
            r_apple_x    <= w_apple_x_nxt;
            r_apple_y    <= w_apple_y_nxt;
            r_apple_type <= w_apple_type_nxt;
            r_apple_vld  <= w_apple_vld_nxt;
            r_body_add   <= w_body_add_nxt;
            r_bonus      <= w_bonus_nxt;
            r_fail       <= w_fail_nxt;
        end
    end

    assign occ.Occ_req   = r_occ_req;
    assign occ.Occ_x     = r_occ_x;
    assign occ.Occ_y     = r_occ_y;
    assign Apple_x       = r_apple_x;
    assign Apple_y       = r_apple_y;
    assign Apple_type    = r_apple_type;
    assign Apple_valid   = r_apple_vld;
    assign Body_add_sig  = r_body_add;
    assign Bonus_sig     = r_bonus;
    assign Spawn_fail    = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_apple_spawner.sv
`default_nettype none
// ============================================================================
// Module   : tb_apple_spawner
// Brief    : Self-checking bench: eat/respawn vectors, bonus lifetime,
//            fallback placement and asynchronous reset mid-handshake.
// Revision : 1.0
// ============================================================================
module tb_apple_spawner;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: fast ticks, bonus every 2nd apple, 3-tick bonus life
    logic [5:0] head_x_a = '0;
    logic [4:0] head_y_a = '0;
    logic [5:0] apple_x_a;
    logic [4:0] apple_y_a;
    logic       type_a, valid_a, body_add_a, bonus_a, fail_a;
    logic       ack_hold = 1'b0;
    int         hits_cfg = 0;
    int         hits_base = 0;
    int         ack_cnt_a = 0;
    logic [5:0] last_qx = '0;
    logic [4:0] last_qy = '0;

    apple_spawner_if #(.X_W(6), .Y_W(5)) occ_a ();
    assign occ_a.Occ_ack = occ_a.Occ_req & ~ack_hold;
    assign occ_a.Occ_hit = ((ack_cnt_a - hits_base) < hits_cfg);

    apple_spawner #(.TICK_CYCLES(10), .BONUS_EVERY(2), .BONUS_LIFE(3), .MAX_TRY(64)) u_a (
        .Clk_50mhz(clk), .Rst_n(rst_n), .Head_x(head_x_a), .Head_y(head_y_a), .occ(occ_a),
        .Apple_x(apple_x_a), .Apple_y(apple_y_a), .Apple_type(type_a), .Apple_valid(valid_a),
        .Body_add_sig(body_add_a), .Bonus_sig(bonus_a), .Spawn_fail(fail_a)
    );

    // Instance B: body always reports occupied, small retry budget
    logic [5:0] head_x_b = '0;
    logic [4:0] head_y_b = '0;
    logic [5:0] apple_x_b;
    logic [4:0] apple_y_b;
    logic       type_b, valid_b, body_add_b, bonus_b, fail_b;

    apple_spawner_if #(.X_W(6), .Y_W(5)) occ_b ();
    assign occ_b.Occ_ack = occ_b.Occ_req;
    assign occ_b.Occ_hit = 1'b1;

    apple_spawner #(.TICK_CYCLES(10), .MAX_TRY(4)) u_b (
        .Clk_50mhz(clk), .Rst_n(rst_n), .Head_x(head_x_b), .Head_y(head_y_b), .occ(occ_b),
        .Apple_x(apple_x_b), .Apple_y(apple_y_b), .Apple_type(type_b), .Apple_valid(valid_b),
        .Body_add_sig(body_add_b), .Bonus_sig(bonus_b), .Spawn_fail(fail_b)
    );

    // Reference tick phase and event counters
    int tb_tc = 0;
    int n_tick = 0;
    int n_ba_a = 0, n_bs_a = 0, n_sf_a = 0, n_sf_b = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_tc <= 0;
        else        tb_tc <= (tb_tc == 9) ? 0 : tb_tc + 1;
    end

    always @(posedge clk) begin
        if (rst_n && tb_tc == 9) n_tick <= n_tick + 1;
        if (occ_a.Occ_req && occ_a.Occ_ack) begin
            ack_cnt_a <= ack_cnt_a + 1;
            last_qx   <= occ_a.Occ_x;
            last_qy   <= occ_a.Occ_y;
        end
        if (body_add_a) n_ba_a <= n_ba_a + 1;
        if (bonus_a)    n_bs_a <= n_bs_a + 1;
        if (fail_a)     n_sf_a <= n_sf_a + 1;
        if (fail_b)     n_sf_b <= n_sf_b + 1;
    end

    int n_checks = 0;
    int n_errors = 0;
    int place_tick = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_valid(input string nm, output int cycles);
        cycles = 0;
        while (!valid_a && cycles < 400) begin
            @(negedge clk);
            cycles++;
        end
        chk({nm, " valid_timeout"}, valid_a, 1);
        place_tick = n_tick;
    endtask

    task automatic eat_a(input string nm, input int hits, input bit exp_bonus,
                         input bit exp_type, input int wait_ticks);
        int  ack0, sf0, bs0, n;
        bit  seen;
        hits_cfg  = hits;
        hits_base = ack_cnt_a;
        ack0 = ack_cnt_a;
        sf0  = n_sf_a;
        bs0  = n_bs_a;
        n = 0;
        while ((n_tick - place_tick) < wait_ticks && n < 200) begin
            @(negedge clk);
            n++;
        end
        head_x_a = apple_x_a;
        head_y_a = apple_y_a;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (body_add_a) seen = 1'b1;
        end
        chk({nm, " eat_seen"}, seen, 1);
        if (seen) begin
            chk({nm, " eat_after_tick"}, tb_tc, 0);
            chk({nm, " bonus_sig"}, bonus_a, exp_bonus);
            chk({nm, " valid_dropped"}, valid_a, 0);
            @(negedge clk);
            chk({nm, " body_add_1cyc"}, body_add_a, 0);
            wait_valid(nm, n);
            chk({nm, " respawn_latency_ge3"}, (n + 1 >= 3), 1);
            chk({nm, " x_in_range"}, (apple_x_a >= 1 && apple_x_a <= 38), 1);
            chk({nm, " y_in_range"}, (apple_y_a >= 1 && apple_y_a <= 28), 1);
            chk({nm, " not_on_head"}, (apple_x_a == head_x_a && apple_y_a == head_y_a), 0);
            chk({nm, " x_is_last_query"}, apple_x_a, last_qx);
            chk({nm, " y_is_last_query"}, apple_y_a, last_qy);
            chk({nm, " requests"}, ack_cnt_a - ack0, hits + 1);
            chk({nm, " no_spawn_fail"}, n_sf_a - sf0, 0);
            chk({nm, " bonus_pulses"}, n_bs_a - bs0, exp_bonus);
            chk({nm, " apple_type"}, type_a, exp_type);
        end
    endtask

    typedef struct {
        string nm;
        int    hits;
        bit    exp_bonus;
        bit    exp_type;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int n, ba0, bs0;
        bit seen;

        vecs[0].nm = "eat_normal"; vecs[0].hits = 0; vecs[0].exp_bonus = 0; vecs[0].exp_type = 0;
        vecs[1].nm = "eat_hits3";  vecs[1].hits = 3; vecs[1].exp_bonus = 0; vecs[1].exp_type = 1;
        vecs[2].nm = "eat_bonus";  vecs[2].hits = 1; vecs[2].exp_bonus = 1; vecs[2].exp_type = 0;
        vecs[3].nm = "eat_hits2";  vecs[3].hits = 2; vecs[3].exp_bonus = 0; vecs[3].exp_type = 1;

        // Reset values and idle behaviour
        repeat (3) @(negedge clk);
        chk("rst_apple_x", apple_x_a, 28);
        chk("rst_apple_y", apple_y_a, 13);
        chk("rst_type", type_a, 0);
        chk("rst_valid", valid_a, 1);
        chk("rst_occ_req", occ_a.Occ_req, 0);
        chk("rst_occ_x", occ_a.Occ_x, 0);
        chk("rst_occ_y", occ_a.Occ_y, 0);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("idle_body_add", n_ba_a, 0);
        chk("idle_bonus", n_bs_a, 0);
        chk("idle_requests", ack_cnt_a, 0);
        chk("idle_apple_x", apple_x_a, 28);
        chk("idle_valid", valid_a, 1);

        for (int i = 0; i < 4; i++)
            eat_a(vecs[i].nm, vecs[i].hits, vecs[i].exp_bonus, vecs[i].exp_type, 0);

        // Uneaten bonus apple expires on its third tick without any pulse
        head_x_a = '0;
        head_y_a = '0;
        ba0 = n_ba_a;
        bs0 = n_bs_a;
        n = 0;
        while (valid_a && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("expire_dropped", valid_a, 0);
        chk("expire_ticks", n_tick - place_tick, 3);
        chk("expire_after_tick", tb_tc, 0);
        chk("expire_no_body_add", n_ba_a - ba0, 0);
        chk("expire_no_bonus", n_bs_a - bs0, 0);
        wait_valid("expire_respawn", n);
        chk("expire_respawn_type", type_a, 0);
        chk("expire_respawn_x", (apple_x_a >= 1 && apple_x_a <= 38), 1);

        // Next apple is bonus; eat it exactly on its expiry tick
        eat_a("make_bonus", 0, 0, 1, 0);
        eat_a("eat_on_expiry", 0, 1, 0, 2);

        // Fallback: every query reports occupied, budget of 4
        head_x_b = 6'd28;
        head_y_b = 5'd13;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (fail_b) seen = 1'b1;
        end
        chk("fallback_pulse", seen, 1);
        @(negedge clk);
        chk("fallback_pulse_1cyc", fail_b, 0);
        chk("fallback_x", apple_x_b, 1);
        chk("fallback_y", apple_y_b, 1);
        chk("fallback_valid", valid_b, 1);
        chk("fallback_type", type_b, 0);
        repeat (30) @(negedge clk);
        chk("fallback_once", n_sf_b, 1);

        // Asynchronous reset while a query is pending
        ack_hold = 1'b1;
        head_x_a = apple_x_a;
        head_y_a = apple_y_a;
        n = 0;
        while (!occ_a.Occ_req && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("midcheck_req_up", occ_a.Occ_req, 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_req_drop", occ_a.Occ_req, 0);
        chk("async_apple_x", apple_x_a, 28);
        chk("async_apple_y", apple_y_a, 13);
        chk("async_type", type_a, 0);
        chk("async_valid", valid_a, 1);
        head_x_a = '0;
        head_y_a = '0;
        ack_hold = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ba0 = n_ba_a;
        n = ack_cnt_a;
        repeat (30) @(negedge clk);
        chk("post_rst_idle_req", ack_cnt_a - n, 0);
        chk("post_rst_no_eat", n_ba_a - ba0, 0);
        chk("post_rst_apple_x", apple_x_a, 28);
        chk("post_rst_valid", valid_a, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
